// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access-size codes and FSM states.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension,
// and misalignment detection. Purely combinational.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLow,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed byte and half-word out of the returned word.
  always_comb begin
    byteSel = loadWord[7:0];
    case (addrLow)
      2'd0: byteSel = loadWord[7:0];
      2'd1: byteSel = loadWord[15:8];
      2'd2: byteSel = loadWord[23:16];
      2'd3: byteSel = loadWord[31:24];
      default: byteSel = loadWord[7:0];
    endcase
    halfSel = addrLow[1] ? loadWord[31:16] : loadWord[15:0];
  end

  // Size-dependent lane enables, store replication, load extension and alignment check.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = 32'd0;
    loadData = 32'd0;
    misalign = 1'b0;
    case (size)
      SIZE_B: begin
        byteEn   = 4'b0001 << addrLow;
        laneData = {4{storeData[7:0]}};
        loadData = isUnsigned ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
      end
      SIZE_H: begin
        misalign = addrLow[0];
        byteEn   = addrLow[1] ? 4'b1100 : 4'b0011;
        laneData = {2{storeData[15:0]}};
        loadData = isUnsigned ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
      end
      default: begin
        misalign = (addrLow != 2'b00);
        byteEn   = 4'b1111;
        laneData = storeData;
        loadData = loadWord;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: accepts one EX/MEM op at a time, runs loads/stores on the
// data-memory bus with a request timeout, and presents the result to MEM/WB.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new op; no memory request outstanding
// ST_WAIT | dmem_req held, waiting for dmem_ack or the timeout
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic                      ex_MemRead,
  input  logic                      ex_MemWrite,
  input  logic                      ex_MemtoReg,
  input  logic                      ex_RegWrite,
  input  logic [4:0]                ex_WriteReg,
  input  logic [31:0]               ex_ALUResult,
  input  logic [31:0]               ex_WriteData,
  input  logic [1:0]                ex_size,
  input  logic                      ex_unsigned,
  output logic                      mem_stall,
  mem_access_unit_if.master         dmemBus,
  output logic                      mem_valid,
  output logic [31:0]               ReadData,
  output logic [31:0]               address,
  output logic [4:0]                WriteReg,
  output logic                      RegWrite,
  output logic                      MemtoReg,
  output logic                      mem_misalign,
  output logic                      bus_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  memState_t state, nextState;
  logic [TO_W-1:0] waitCnt;

  logic        opWrite, opUnsigned, opRegWrite, opMemtoReg;
  logic [1:0]  opSize;
  logic [4:0]  opWriteReg;
  logic [31:0] opAddress;

  logic [1:0]  alnSize, alnAddrLow;
  logic        alnUnsigned, alnMisalign;
  logic [3:0]  alnBe;
  logic [31:0] alnWdata, alnLoad;

  logic idlePass, idleMisalign, idleStart, waitAck, waitTimeout;

  // In WAIT the aligner works on the captured op so the load lane matches the request.
  assign alnSize     = (state == ST_WAIT) ? opSize          : ex_size;
  assign alnAddrLow  = (state == ST_WAIT) ? opAddress[1:0]  : ex_ALUResult[1:0];
  assign alnUnsigned = (state == ST_WAIT) ? opUnsigned      : ex_unsigned;

  mem_lane_align uAlign (
    .size       (alnSize),
    .addrLow    (alnAddrLow),
    .isUnsigned (alnUnsigned),
    .storeData  (ex_WriteData),
    .loadWord   (dmemBus.dmem_rdata),
    .byteEn     (alnBe),
    .laneData   (alnWdata),
    .loadData   (alnLoad),
    .misalign   (alnMisalign)
  );

  assign mem_stall = (state == ST_WAIT);

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Next-state and per-cycle event decode; ack takes priority over timeout.
  always_comb begin
    nextState    = state;
    idlePass     = 1'b0;
    idleMisalign = 1'b0;
    idleStart    = 1'b0;
    waitAck      = 1'b0;
    waitTimeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!(ex_MemRead || ex_MemWrite)) begin
            idlePass = 1'b1;
          end else if (alnMisalign) begin
            idleMisalign = 1'b1;
          end else begin
            idleStart = 1'b1;
            nextState = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmemBus.dmem_ack) begin
          waitAck   = 1'b1;
          nextState = ST_IDLE;
        end else if (waitCnt == TO_W'(TIMEOUT - 1)) begin
          waitTimeout = 1'b1;
          nextState   = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Cycles spent in WAIT without an ack; cleared whenever WAIT is left or entered.
  always_ff @(posedge clock) begin
    if (rst)                                            waitCnt <= '0;
    else if (state == ST_WAIT && nextState == ST_WAIT) waitCnt <= waitCnt + 1'b1;
    else                                                waitCnt <= '0;
  end

  // Memory bus, captured op and MEM/WB output registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      dmemBus.dmem_req   <= 1'b0;
      dmemBus.dmem_we    <= 1'b0;
      dmemBus.dmem_addr  <= 32'd0;
      dmemBus.dmem_be    <= 4'd0;
      dmemBus.dmem_wdata <= 32'd0;
      opWrite    <= 1'b0;
      opUnsigned <= 1'b0;
      opRegWrite <= 1'b0;
      opMemtoReg <= 1'b0;
      opSize     <= 2'd0;
      opWriteReg <= 5'd0;
      opAddress  <= 32'd0;
      mem_valid    <= 1'b0;
      ReadData     <= 32'd0;
      address      <= 32'd0;
      WriteReg     <= 5'd0;
      RegWrite     <= 1'b0;
      MemtoReg     <= 1'b0;
      mem_misalign <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      mem_valid    <= 1'b0;
      mem_misalign <= 1'b0;
      bus_err      <= 1'b0;
      if (idlePass || idleMisalign) begin
        mem_valid    <= 1'b1;
        mem_misalign <= idleMisalign;
        address      <= ex_ALUResult;
        WriteReg     <= ex_WriteReg;
        RegWrite     <= ex_RegWrite & ~idleMisalign;
        MemtoReg     <= ex_MemtoReg;
        ReadData     <= 32'd0;
      end
      if (idleStart) begin
        dmemBus.dmem_req   <= 1'b1;
        dmemBus.dmem_we    <= ex_MemWrite;
        dmemBus.dmem_addr  <= {ex_ALUResult[31:2], 2'b00};
        dmemBus.dmem_be    <= alnBe;
        dmemBus.dmem_wdata <= alnWdata;
        opWrite    <= ex_MemWrite;
        opUnsigned <= ex_unsigned;
        opRegWrite <= ex_RegWrite;
        opMemtoReg <= ex_MemtoReg;
        opSize     <= ex_size;
        opWriteReg <= ex_WriteReg;
        opAddress  <= ex_ALUResult;
      end
      if (waitAck || waitTimeout) begin
        dmemBus.dmem_req <= 1'b0;
        mem_valid <= 1'b1;
        bus_err   <= waitTimeout;
        address   <= opAddress;
        WriteReg  <= opWriteReg;
        RegWrite  <= opRegWrite & ~waitTimeout;
        MemtoReg  <= opMemtoReg;
        ReadData  <= (waitAck && !opWrite) ? alnLoad : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for the MEM stage with a small data-memory responder and
// scoreboards for both the memory requests and the MEM/WB results.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic        berr;
  } outExp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } reqExp_t;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_MemRead = 1'b0, ex_MemWrite = 1'b0;
  logic        ex_MemtoReg = 1'b0, ex_RegWrite = 1'b0, ex_unsigned = 1'b0;
  logic [4:0]  ex_WriteReg = 5'd0;
  logic [31:0] ex_ALUResult = 32'd0, ex_WriteData = 32'd0;
  logic [1:0]  ex_size = 2'd0;
  logic        mem_stall, mem_valid, RegWrite, MemtoReg, mem_misalign, bus_err;
  logic [31:0] ReadData, address;
  logic [4:0]  WriteReg;

  mem_access_unit_if dmemBus();

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clock(clock), .rst(rst),
    .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_WriteReg(ex_WriteReg),
    .ex_ALUResult(ex_ALUResult), .ex_WriteData(ex_WriteData), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .mem_stall(mem_stall), .dmemBus(dmemBus),
    .mem_valid(mem_valid), .ReadData(ReadData), .address(address), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .mem_misalign(mem_misalign), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  outExp_t expQ[$];
  reqExp_t reqQ[$];
  int ackDelay = -1;
  logic [31:0] rdataVal = 32'd0;
  logic forceAck = 1'b0;
  int reqCycles = 0;
  int lastReqLen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pushOut(input logic [31:0] a, rd, input logic [4:0] wr,
                         input logic rw, m2r, mis, berr);
    outExp_t e;
    e.addr = a; e.rdata = rd; e.wreg = wr; e.rw = rw; e.m2r = m2r; e.mis = mis; e.berr = berr;
    expQ.push_back(e);
  endtask

  task automatic pushReq(input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic we);
    reqExp_t r;
    r.addr = a; r.be = be; r.wdata = wd; r.we = we;
    reqQ.push_back(r);
  endtask

  // Present one op for exactly one accept edge; optionally check accept-to-valid latency.
  task automatic sendOp(input logic rd, wr, m2r, rw, input logic [4:0] wreg,
                        input logic [31:0] addr, wdata, input logic [1:0] size,
                        input logic uns, input int lat, input string name);
    @(posedge clock); #1;
    ex_valid = 1'b1; ex_MemRead = rd; ex_MemWrite = wr; ex_MemtoReg = m2r;
    ex_RegWrite = rw; ex_WriteReg = wreg; ex_ALUResult = addr; ex_WriteData = wdata;
    ex_size = size; ex_unsigned = uns;
    @(posedge clock); #1;
    ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
    if (lat > 0) begin
      repeat (lat - 1) @(posedge clock);
      @(negedge clock);
      chk({name, "_latency_mem_valid"}, 32'(mem_valid), 32'd1);
    end
  endtask

  task automatic waitDone(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (expQ.size() == 0 && reqQ.size() == 0 && !mem_stall) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_completion got pending=%0d expected pending=0", name, expQ.size());
    end
  endtask

  // Output monitor: every mem_valid pops one expected MEM/WB result.
  initial forever begin
    outExp_t e;
    @(negedge clock);
    if (mem_valid) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_valid got address %h expected no output", address);
      end else begin
        e = expQ.pop_front();
        chk("out_address", address, e.addr);
        chk("out_ReadData", ReadData, e.rdata);
        chk("out_WriteReg", 32'(WriteReg), 32'(e.wreg));
        chk("out_RegWrite", 32'(RegWrite), 32'(e.rw));
        chk("out_MemtoReg", 32'(MemtoReg), 32'(e.m2r));
        chk("out_misalign", 32'(mem_misalign), 32'(e.mis));
        chk("out_bus_err", 32'(bus_err), 32'(e.berr));
      end
    end
  end

  // Data-memory responder: checks each new request, acks after ackDelay req cycles.
  initial begin
    reqExp_t r;
    dmemBus.dmem_ack = 1'b0;
    dmemBus.dmem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      dmemBus.dmem_ack = 1'b0;
      if (dmemBus.dmem_req) begin
        if (reqCycles == 0) begin
          if (reqQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dmem_req got addr %h expected no request", dmemBus.dmem_addr);
          end else begin
            r = reqQ.pop_front();
            chk("req_addr", dmemBus.dmem_addr, r.addr);
            chk("req_be", 32'(dmemBus.dmem_be), 32'(r.be));
            chk("req_wdata", dmemBus.dmem_wdata, r.wdata);
            chk("req_we", 32'(dmemBus.dmem_we), 32'(r.we));
          end
        end
        chk("stall_in_wait", 32'(mem_stall), 32'd1);
        chk("no_valid_in_wait", 32'(mem_valid), 32'd0);
        if (reqCycles == ackDelay) begin
          dmemBus.dmem_ack = 1'b1;
          dmemBus.dmem_rdata = rdataVal;
        end
        reqCycles++;
      end else begin
        if (reqCycles != 0) lastReqLen = reqCycles;
        reqCycles = 0;
        if (forceAck) dmemBus.dmem_ack = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmemBus.dmem_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_ReadData", ReadData, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_dmem_be", 32'(dmemBus.dmem_be), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clock); #1 rst = 1'b0;

    // ALU pass-through, one cycle latency
    pushOut(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    sendOp(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, SIZE_W, 1'b0, 1, "alu");
    waitDone("alu");

    // Idle with a stray ack: nothing must happen
    @(posedge clock); #1 forceAck = 1'b1;
    @(posedge clock); #1 forceAck = 1'b0;
    @(negedge clock);
    chk("idle_ack_mem_valid", 32'(mem_valid), 32'd0);
    chk("idle_ack_dmem_req", 32'(dmemBus.dmem_req), 32'd0);
    chk("idle_ack_mem_stall", 32'(mem_stall), 32'd0);

    // LB 0x103, ack one cycle late
    ackDelay = 1; rdataVal = 32'h80FF_0000;
    pushReq(32'h100, 4'b1000, 32'h0, 1'b0);
    pushOut(32'h103, 32'hFFFF_FF80, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h103, 32'h0, SIZE_B, 1'b0, 3, "lb");
    waitDone("lb");

    // LBU 0x103
    pushReq(32'h100, 4'b1000, 32'h0, 1'b0);
    pushOut(32'h103, 32'h0000_0080, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h103, 32'h0, SIZE_B, 1'b1, 3, "lbu");
    waitDone("lbu");

    // SH 0x202, immediate ack: minimum latency of two
    ackDelay = 0;
    pushReq(32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1);
    pushOut(32'h202, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendOp(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h202, 32'h0000_ABCD, SIZE_H, 1'b0, 2, "sh");
    waitDone("sh");

    // SB 0x101
    pushReq(32'h100, 4'b0010, 32'h5A5A_5A5A, 1'b1);
    pushOut(32'h101, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendOp(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h101, 32'h1234_565A, SIZE_B, 1'b0, 2, "sb");
    waitDone("sb");

    // SW 0x300
    pushReq(32'h300, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    pushOut(32'h300, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendOp(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h300, 32'hDEAD_BEEF, SIZE_W, 1'b0, 2, "sw");
    waitDone("sw");

    // LH 0x2 signed, LHU 0x0
    rdataVal = 32'h8001_1234;
    pushReq(32'h0, 4'b1100, 32'h0, 1'b0);
    pushOut(32'h2, 32'hFFFF_8001, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h2, 32'h0, SIZE_H, 1'b0, 2, "lh");
    waitDone("lh");
    rdataVal = 32'h8001_F234;
    pushReq(32'h0, 4'b0011, 32'h0, 1'b0);
    pushOut(32'h0, 32'h0000_F234, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0, 32'h0, SIZE_H, 1'b1, 2, "lhu");
    waitDone("lhu");

    // LW 0x400
    rdataVal = 32'h1234_5678;
    pushReq(32'h400, 4'b1111, 32'h0, 1'b0);
    pushOut(32'h400, 32'h1234_5678, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h400, 32'h0, SIZE_W, 1'b0, 2, "lw");
    waitDone("lw");

    // Misaligned LW 0x6 and SH 0x203: no request, one-cycle result
    pushOut(32'h6, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h6, 32'h0, SIZE_W, 1'b0, 1, "lw_mis");
    waitDone("lw_mis");
    pushOut(32'h203, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendOp(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h203, 32'h1111, SIZE_H, 1'b0, 1, "sh_mis");
    waitDone("sh_mis");

    // Ack in the final allowed cycle beats the timeout
    ackDelay = 15; rdataVal = 32'hCAFE_F00D;
    pushReq(32'h700, 4'b1111, 32'h0, 1'b0);
    pushOut(32'h700, 32'hCAFE_F00D, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h700, 32'h0, SIZE_W, 1'b0, 17, "ack_last");
    waitDone("ack_last");
    @(negedge clock);
    chk("ack_last_req_cycles", 32'(lastReqLen), 32'd16);

    // Ack withheld: bus error after 16 request cycles
    ackDelay = -1;
    pushReq(32'h500, 4'b1111, 32'h0, 1'b0);
    pushOut(32'h500, 32'd0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h500, 32'h0, SIZE_W, 1'b0, 17, "timeout");
    chk("timeout_stall_dropped", 32'(mem_stall), 32'd0);
    waitDone("timeout");
    @(negedge clock);
    chk("timeout_req_cycles", 32'(lastReqLen), 32'd16);

    // Reset during WAIT cycle 3 drops the op
    pushReq(32'h600, 4'b1111, 32'h0, 1'b0);
    sendOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h600, 32'h0, SIZE_W, 1'b0, 0, "rst_wait");
    @(posedge clock);
    @(posedge clock); #1 rst = 1'b1;
    @(posedge clock); #1 rst = 1'b0;
    @(negedge clock);
    chk("rst_wait_dmem_req", 32'(dmemBus.dmem_req), 32'd0);
    chk("rst_wait_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_wait_mem_stall", 32'(mem_stall), 32'd0);
    repeat (3) @(negedge clock);
    chk("end_out_queue_empty", 32'(expQ.size()), 32'd0);
    chk("end_req_queue_empty", 32'(reqQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
